// File: rtl/mc_shift_unit_pkg.sv
// Shared definitions for the multi-cycle shifter: ALUFun shift encodings,
// FSM state type and the STEP legality check.
package mc_shift_pkg;

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b11;
  localparam logic [1:0] OP_PASS = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic bit step_legal(input int step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8);
  endfunction

endpackage

// File: rtl/mc_shift_unit_if.sv
// Request/response bundle between the control FSM (master) and the shifter
// (slave), plus the shifter's FSM state for observation.
interface mc_shift_unit_if;
  import mc_shift_pkg::*;

  // start is sampled only while the shifter is in IDLE or DONE; it is ignored
  // while busy=1. done is a single-cycle pulse, and S is valid from then on
  // and holds until the next done.
  logic        start;
  logic [1:0]  ALUFun;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] S;
  state_t      state;

  modport master (output start, ALUFun, A, B, input busy, done, S, state);
  modport slave  (input start, ALUFun, A, B, output busy, done, S, state);

endinterface

// File: rtl/mc_shift_unit_step.sv
// One combinational shift step of up to STEP bits. SRA fills with value[31],
// so chaining steps yields the same result as a single arithmetic shift.
module shift_step
  import mc_shift_pkg::*;
(
  input  logic [31:0] value,
  input  logic [3:0]  k,
  input  logic [1:0]  op,
  output logic [31:0] shifted
);

  always_comb begin
    shifted = value;
    case (op)
      OP_SLL:  shifted = value << k;
      OP_SRL:  shifted = value >> k;
      OP_SRA:  shifted = $signed(value) >>> k;
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/mc_shift_unit.sv
// Multi-cycle SLL/SRL/SRA unit: shifts at most STEP bits per clock and
// reports completion with a one-cycle done pulse and a held result register.
module mc_shift_unit
  import mc_shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  mc_shift_unit_if.slave  bus
);

  if (!step_legal(STEP)) begin : g_bad_step
    $error("mc_shift_unit: STEP must be 1, 2, 4 or 8");
  end

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] s_q, s_d;
  logic [3:0]  step_k;
  logic [31:0] acc_shifted;
  logic        unused_a_hi;

  // Only A[4:0] is a shift amount; the upper bits are architecturally ignored.
  assign unused_a_hi = ^bus.A[31:5];

  assign step_k = (cnt_q > STEP5) ? STEP5[3:0] : cnt_q[3:0];

  shift_step u_step (
    .value   (acc_q),
    .k       (step_k),
    .op      (op_q),
    .shifted (acc_shifted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= OP_SLL;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    s_d     = s_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          acc_d   = bus.B;
          cnt_d   = (bus.ALUFun == OP_PASS) ? 5'd0 : bus.A[4:0];
          op_d    = bus.ALUFun;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q != 5'd0) begin
          acc_d = acc_shifted;
          cnt_d = cnt_q - {1'b0, step_k};
        end else begin
          s_d     = acc_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_mc_shift_unit.sv
// Directed bench for mc_shift_unit with STEP=1 and STEP=4 instances sharing
// one clock and reset; expected results and latencies are hand-computed.
module tb_mc_shift_unit;
  import mc_shift_pkg::*;

  localparam int LIMIT = 60;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mc_shift_unit_if if1 ();
  mc_shift_unit_if if4 ();

  mc_shift_unit #(.STEP(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  mc_shift_unit #(.STEP(4)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_busy(input int w);
    return (w == 1) ? if1.busy : if4.busy;
  endfunction

  function automatic logic sel_done(input int w);
    return (w == 1) ? if1.done : if4.done;
  endfunction

  task automatic drive(input int w, input logic st, input logic [1:0] fun,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 1) begin
      if1.start = st; if1.ALUFun = fun; if1.A = a; if1.B = b;
    end else begin
      if4.start = st; if4.ALUFun = fun; if4.A = a; if4.B = b;
    end
  endtask

  // Called #1 after a rising edge; returns edges from the start edge to done.
  task automatic run_op(input int w, input logic [1:0] fun, input logic [31:0] a,
                        input logic [31:0] b, input int inj_at,
                        output int n, output int busy_n, output int dones);
    drive(w, 1'b1, fun, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, 2'(fun ^ 2'b01), $urandom, $urandom);
    n = 0;
    dones = 0;
    busy_n = sel_busy(w) ? 1 : 0;
    while (n < LIMIT) begin
      if (inj_at != 0 && n + 1 == inj_at) drive(w, 1'b1, OP_SLL, 32'd1, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      n++;
      drive(w, 1'b0, OP_SLL, 32'd0, 32'd0);
      if (sel_busy(w)) busy_n++;
      if (sel_done(w)) begin
        dones++;
        break;
      end
    end
  endtask

  initial begin
    int n, busy_n, dones;
    logic [31:0] held;
    drive(1, 1'b0, OP_SLL, 32'd0, 32'd0);
    drive(4, 1'b0, OP_SLL, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy1", 32'(if1.busy), 32'd0);
    chk("rst_done1", 32'(if1.done), 32'd0);
    chk("rst_s1", if1.S, 32'd0);
    chk("rst_state1", 32'(if1.state), 32'(IDLE));
    chk("rst_s4", if4.S, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // SLL by 31, one bit per clock
    run_op(1, OP_SLL, 32'd31, 32'h0000_0001, 0, n, busy_n, dones);
    chk("sll31_lat", 32'(n), 32'd32);
    chk("sll31_busy", 32'(busy_n), 32'd32);
    chk("sll31_s", if1.S, 32'h8000_0000);
    @(posedge clk); #1;
    chk("sll31_done_drop", 32'(if1.done), 32'd0);
    chk("sll31_s_hold", if1.S, 32'h8000_0000);

    run_op(4, OP_SRA, 32'd4, 32'h8000_0000, 0, n, busy_n, dones);
    chk("sra4_lat", 32'(n), 32'd2);
    chk("sra4_s", if4.S, 32'hF800_0000);
    run_op(4, OP_SRL, 32'd4, 32'h8000_0000, 0, n, busy_n, dones);
    chk("srl4_lat", 32'(n), 32'd2);
    chk("srl4_s", if4.S, 32'h0800_0000);
    run_op(4, OP_SRA, 32'hFFFF_FFE4, 32'h8000_0000, 0, n, busy_n, dones);
    chk("sra_ahi_lat", 32'(n), 32'd2);
    chk("sra_ahi_s", if4.S, 32'hF800_0000);

    run_op(4, OP_SLL, 32'd0, 32'h1234_5678, 0, n, busy_n, dones);
    chk("zero_lat", 32'(n), 32'd1);
    chk("zero_s", if4.S, 32'h1234_5678);
    run_op(4, OP_PASS, 32'd17, 32'h1234_5678, 0, n, busy_n, dones);
    chk("pass_lat", 32'(n), 32'd1);
    chk("pass_s", if4.S, 32'h1234_5678);

    // 5 with STEP=4 takes a 4-step then a 1-step
    run_op(4, OP_SLL, 32'd5, 32'h0000_0001, 0, n, busy_n, dones);
    chk("sll5_lat", 32'(n), 32'd3);
    chk("sll5_s", if4.S, 32'h0000_0020);
    run_op(4, OP_SRA, 32'd31, 32'h8000_0000, 0, n, busy_n, dones);
    chk("sra31_lat", 32'(n), 32'd9);
    chk("sra31_s", if4.S, 32'hFFFF_FFFF);
    run_op(4, OP_SRA, 32'd31, 32'h4000_0000, 0, n, busy_n, dones);
    chk("sra31_pos_s", if4.S, 32'h0000_0000);

    // start pulsed mid-RUN must be ignored
    run_op(1, OP_SRL, 32'd8, 32'h8000_0000, 3, n, busy_n, dones);
    chk("ign_lat", 32'(n), 32'd9);
    chk("ign_s", if1.S, 32'h0080_0000);
    repeat (4) begin
      @(posedge clk); #1;
      if (if1.done) dones++;
    end
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_state", 32'(if1.state), 32'(IDLE));
    chk("ign_s_hold", if1.S, 32'h0080_0000);

    // back-to-back: second start issued in the DONE cycle
    run_op(4, OP_SLL, 32'd8, 32'h0000_0001, 0, n, busy_n, dones);
    chk("b2b1_lat", 32'(n), 32'd3);
    chk("b2b1_s", if4.S, 32'h0000_0100);
    run_op(4, OP_SRL, 32'd4, 32'h0000_00F0, 0, n, busy_n, dones);
    chk("b2b2_lat", 32'(n), 32'd2);
    chk("b2b2_busy", 32'(busy_n), 32'd2);
    chk("b2b2_s", if4.S, 32'h0000_000F);

    // reset asserted in the middle of a 31-bit shift
    held = if1.S;
    chk("pre_rst_s", held, 32'h0080_0000);
    drive(1, 1'b1, OP_SLL, 32'd31, 32'h0000_0001);
    @(posedge clk); #1;
    drive(1, 1'b0, OP_SLL, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 32'(if1.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mrst_busy", 32'(if1.busy), 32'd0);
    chk("mrst_done", 32'(if1.done), 32'd0);
    chk("mrst_s", if1.S, 32'd0);
    chk("mrst_state", 32'(if1.state), 32'(IDLE));
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", 32'(if1.state), 32'(IDLE));
    run_op(1, OP_SRL, 32'd3, 32'h0000_0080, 0, n, busy_n, dones);
    chk("post_rst_lat", 32'(n), 32'd4);
    chk("post_rst_s", if1.S, 32'h0000_0010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
